ram_wait_states: RTL

Parametrised synchronous successor of the sEP8 bus RAM model: data width, address width, depth and per-direction wait states are configurable. A bus access uses the active-low strobes (s_, mr_, mw_), and the block answers with an active-low ready handshake after a programmable number of wait cycles. It sits on the processor memory bus as the main memory, in place of the fixed-delay asynchronous model, and gives the processor's wait-state logic a deterministic, cycle-exact target.

---
 rtl/ram_pkg.sv | 22 ++
 rtl/ram_wait_states_if.sv | 13 +
 rtl/ram_array.sv | 43 ++++
 rtl/ram_wait_states.sv | 132 +++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and sizing helpers for the wait-state bus RAM.
package ram_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_WAIT  = 2'd1;
    localparam state_t ST_READY = 2'd2;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    // Wait counter must hold the larger wait count minus one; never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned wait_r, input int unsigned wait_w);
        int unsigned max_wait;
        max_wait = (wait_r > wait_w) ? wait_r : wait_w;
        return (max_wait == 0) ? 1 : $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/ram_wait_states_if.sv
// Processor memory-bus strobes and ready handshake (data bus stays a plain inout net).
interface ram_wait_states_if #(
    parameter int unsigned ADDR_W = 24
);
    logic [ADDR_W-1:0] a;
    logic              s_;
    logic              mr_;
    logic              mw_;
    logic              rdy_;

    modport master (output a, s_, mr_, mw_, input rdy_);
    modport slave  (input a, s_, mr_, mw_, output rdy_);
endinterface

// File: rtl/ram_array.sv
// Single-port synchronous storage with registered read; no handshake logic so a macro can replace it.
module ram_array #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[addr];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ram_wait_states.sv
// Bus RAM answering s_/mr_/mw_ accesses with rdy_ after a fixed, per-direction number of wait cycles.
module ram_wait_states
    import ram_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 24,
    parameter int unsigned DEPTH  = 1 << ADDR_W,
    parameter int unsigned WAIT_R = 2,
    parameter int unsigned WAIT_W = 2
) (
    input  logic              clock,
    input  logic              reset,
    ram_wait_states_if.slave  bus,
    inout  wire [DATA_W-1:0]  d
);

    localparam int unsigned CNT_W  = cnt_width(WAIT_R, WAIT_W);
    localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    op_e               op_q, op_d;
    logic              inr_q, inr_d;
    logic              rdy_n_q, rdy_n_d;
    logic              drive_q, drive_d;

    logic              req_c;
    op_e               req_op_c;
    logic              req_inr_c;
    logic [CNT_W-1:0]  wait_sel_c;
    logic              rel_c;
    logic              enter_c;
    logic              mem_we_c;
    logic              mem_re_c;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] dout_c;

    // Request decode; both strobes low is illegal and never starts an access.
    assign req_c      = !bus.s_ && (bus.mr_ ^ bus.mw_);
    assign req_op_c   = bus.mw_ ? OP_READ : OP_WRITE;
    assign req_inr_c  = 64'(bus.a) < 64'(DEPTH);
    assign wait_sel_c = (req_op_c == OP_WRITE) ? CNT_W'(WAIT_W) : CNT_W'(WAIT_R);
    assign rel_c      = bus.s_ | ((op_q == OP_WRITE) ? bus.mw_ : bus.mr_);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        op_d    = op_q;
        inr_d   = inr_q;
        enter_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_c) begin
                    addr_d = bus.a;
                    op_d   = req_op_c;
                    inr_d  = req_inr_c;
                    if (wait_sel_c == '0) begin
                        state_d = ST_READY;
                        enter_c = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = wait_sel_c - CNT_W'(1);
                    end
                end
            end
            ST_WAIT: begin
                if (rel_c) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_READY;
                    enter_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_READY: begin
                if (rel_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The memory access happens on the edge that enters READY, using the effective latch values.
        rdy_n_d  = (state_d != ST_READY);
        drive_d  = (state_d == ST_READY) && (op_d == OP_READ);
        mem_we_c = enter_c && !reset && (op_d == OP_WRITE) && inr_d;
        mem_re_c = enter_c && !reset && (op_d == OP_READ) && inr_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            op_q    <= OP_READ;
            inr_q   <= 1'b0;
            rdy_n_q <= 1'b1;
            drive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            inr_q   <= inr_d;
            rdy_n_q <= rdy_n_d;
            drive_q <= drive_d;
        end
    end

    ram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (MEM_AW)
    ) u_array (
        .clock  (clock),
        .reset  (reset),
        .we     (mem_we_c),
        .re     (mem_re_c),
        .addr   (MEM_AW'(addr_d)),
        .wdata  (d),
        .rdata  (rdata)
    );

    // Out-of-range reads return zeros without touching the array.
    assign dout_c   = inr_q ? rdata : '0;
    assign d        = drive_q ? dout_c : {DATA_W{1'bz}};
    assign bus.rdy_ = rdy_n_q;

endmodule
